// File: rtl/byte_mux_arbiter_pkg.sv
// Shared types and constants for the two-source byte arbiter.
// Source encoding matches O_SRC and SEL: 0 = requester A, 1 = requester B.
package byte_mux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_t;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/byte_mux_arbiter_if.sv
// Producer/consumer bundle around the arbiter.
// Handshake rule on every channel: a beat transfers on a rising edge where VALID and READY
// are both 1; VALID/DATA from a producer stay put until that happens; READY is combinational.
interface byte_mux_arbiter_if #(
  parameter int k = 8
);
  logic         A_VALID;
  logic [k-1:0] A_DATA;
  logic         A_READY;
  logic         B_VALID;
  logic [k-1:0] B_DATA;
  logic         B_READY;
  logic         O_VALID;
  logic [k-1:0] O_DATA;
  logic         O_SRC;
  logic         O_READY;
  logic         SEL;

  modport master (
    output A_VALID, A_DATA, B_VALID, B_DATA, O_READY,
    input  A_READY, B_READY, O_VALID, O_DATA, O_SRC, SEL
  );

  modport slave (
    input  A_VALID, A_DATA, B_VALID, B_DATA, O_READY,
    output A_READY, B_READY, O_VALID, O_DATA, O_SRC, SEL
  );
endinterface

// File: rtl/byte_mux_arbiter_mux.sv
// Plain 2:1 data select; sel_i = 1 picks b_i.
module MuxByte2to1 #(
  parameter int k = 8
) (
  input  logic [k-1:0] a_i,
  input  logic [k-1:0] b_i,
  input  logic         sel_i,
  output logic [k-1:0] y_o
);
  assign y_o = sel_i ? b_i : a_i;
endmodule

// File: rtl/byte_mux_arbiter.sv
// Burst-limited round-robin arbiter sharing one byte path between A and B,
// feeding a single registered output stage with valid/ready.
module byte_mux_arbiter
  import byte_mux_pkg::*;
#(
  parameter int  k        = 8,
  parameter int  MAXBURST = 4,
  localparam int CW       = $clog2(MAXBURST + 1)
) (
  input  logic                CLK,
  input  logic                RST,
  byte_mux_arbiter_if.slave   bus,
  output arb_state_t          dbg_state_o,
  output logic [CW-1:0]       dbg_cnt_o,
  output logic                dbg_last_o
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAXBURST);

  arb_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          o_valid_q, o_valid_d;
  logic [k-1:0]  o_data_q, o_data_d;
  logic          o_src_q, o_src_d;

  logic          ld;
  logic          below_max;
  logic          grant_a, grant_b;
  logic [k-1:0]  mux_data;

  assign ld        = ~o_valid_q | bus.O_READY;
  assign below_max = (cnt_q < MAX_CNT);

  // Grants are suppressed during RST so no producer sees READY in the reset cycle.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!RST) begin
      unique case (state_q)
        IDLE: begin
          if (bus.A_VALID && bus.B_VALID) begin
            grant_a = last_q;
            grant_b = ~last_q;
          end else begin
            grant_a = bus.A_VALID;
            grant_b = bus.B_VALID;
          end
        end
        OWN_A: begin
          if (bus.A_VALID && (below_max || !bus.B_VALID)) grant_a = 1'b1;
          else if (bus.B_VALID)                           grant_b = 1'b1;
        end
        OWN_B: begin
          if (bus.B_VALID && (below_max || !bus.A_VALID)) grant_b = 1'b1;
          else if (bus.A_VALID)                           grant_a = 1'b1;
        end
        default: ;
      endcase
    end
  end

  MuxByte2to1 #(.k(k)) u_mux (
    .a_i   (bus.A_DATA),
    .b_i   (bus.B_DATA),
    .sel_i (grant_b),
    .y_o   (mux_data)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_src_d   = o_src_q;
    if (ld) begin
      if (grant_a || grant_b) begin
        o_valid_d = 1'b1;
        o_data_d  = mux_data;
        o_src_d   = grant_b ? SRC_B : SRC_A;
        last_d    = grant_b ? SRC_B : SRC_A;
        state_d   = grant_b ? OWN_B : OWN_A;
        if ((grant_a && state_q == OWN_A) || (grant_b && state_q == OWN_B)) begin
          cnt_d = below_max ? cnt_q + CW'(1) : cnt_q;
        end else begin
          cnt_d = CW'(1);
        end
      end else begin
        o_valid_d = 1'b0;
        state_d   = IDLE;
        cnt_d     = '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= SRC_B;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_src_q   <= SRC_A;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_src_q   <= o_src_d;
    end
  end

  assign bus.A_READY = ld & grant_a;
  assign bus.B_READY = ld & grant_b;
  assign bus.SEL     = grant_b;
  assign bus.O_VALID = o_valid_q;
  assign bus.O_DATA  = o_data_q;
  assign bus.O_SRC   = o_src_q;

  assign dbg_state_o = state_q;
  assign dbg_cnt_o   = cnt_q;
  assign dbg_last_o  = last_q;

endmodule

// File: tb/tb_byte_mux_arbiter.sv
// Bench for byte_mux_arbiter: directed scenarios plus random traffic, each cycle checked
// against a behavioural arbitration model and an output-order scoreboard.
module tb_byte_mux_arbiter;
  import byte_mux_pkg::*;

  localparam int K    = 8;
  localparam int MAXB = 4;
  localparam int CW   = $clog2(MAXB + 1);

  logic          clk;
  logic          rst;
  arb_state_t    dbg_state;
  logic [CW-1:0] dbg_cnt;
  logic          dbg_last;

  byte_mux_arbiter_if #(.k(K)) bus ();

  byte_mux_arbiter #(.k(K), .MAXBURST(MAXB)) dut (
    .CLK         (clk),
    .RST         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state),
    .dbg_cnt_o   (dbg_cnt),
    .dbg_last_o  (dbg_last)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------- reference model ----------------
  int          m_owner;   // -1 none, 0 A, 1 B
  int          m_run;     // consecutive grants to m_owner, capped at MAXB
  int          m_last;    // last winner, 0 A / 1 B
  bit          m_ovalid;
  logic [K-1:0] m_odata;
  bit          m_osrc;

  logic [K:0] exp_q[$];

  logic [2:0]   e_pre, o_pre;
  logic [K+1:0] e_post, o_post;
  bit           sb_got;
  logic [K:0]   sb_obs, sb_exp;

  function automatic void model_reset();
    m_owner  = -1;
    m_run    = 0;
    m_last   = 1;
    m_ovalid = 1'b0;
    m_odata  = '0;
    m_osrc   = 1'b0;
  endfunction

  function automatic int model_pick(bit av, bit bv);
    if (av && bv) begin
      if (m_owner < 0)   return 1 - m_last;
      if (m_run < MAXB)  return m_owner;
      return 1 - m_owner;
    end
    if (av) return 0;
    if (bv) return 1;
    return -1;
  endfunction

  // ---------------- driver ----------------
  task automatic drive_cycle(input bit r, input bit av, input logic [K-1:0] ad,
                             input bit bv, input logic [K-1:0] bd, input bit ordy);
    int win;
    bit ld;
    @(negedge clk);
    rst         = r;
    bus.A_VALID = av;
    bus.A_DATA  = ad;
    bus.B_VALID = bv;
    bus.B_DATA  = bd;
    bus.O_READY = ordy;
    #1;
    sb_got = 1'b0;
    if (!r && m_ovalid && ordy) begin
      sb_got = 1'b1;
      sb_obs = {bus.O_SRC, bus.O_DATA};
      if (exp_q.size() > 0) sb_exp = exp_q.pop_front();
      else                  sb_exp = ~sb_obs;
    end
    win   = r ? -1 : model_pick(av, bv);
    ld    = !m_ovalid || ordy;
    e_pre = {ld && win == 0, ld && win == 1, win == 1};
    o_pre = {bus.A_READY, bus.B_READY, bus.SEL};
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
      exp_q.delete();
    end else if (ld) begin
      if (win >= 0) begin
        m_run    = (win == m_owner) ? ((m_run + 1 > MAXB) ? MAXB : m_run + 1) : 1;
        m_owner  = win;
        m_last   = win;
        m_ovalid = 1'b1;
        m_osrc   = (win == 1);
        m_odata  = (win == 1) ? bd : ad;
        exp_q.push_back({m_osrc, m_odata});
      end else begin
        m_ovalid = 1'b0;
        m_owner  = -1;
        m_run    = 0;
      end
    end
    e_post = {m_ovalid, m_osrc, m_odata};
    o_post = {bus.O_VALID, bus.O_SRC, bus.O_DATA};
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1, 1'b1, 8'hA5, 1'b1, 8'h5A, 1'b1);
      tests++;
      if (o_pre !== 3'b000) begin
        fails++;
        $display("FAIL reset_ready cyc%0d: got {ar,br,sel}=%b want 000", i, o_pre);
      end
    end
    tests++;
    if (o_post !== '0 || dbg_state !== IDLE || dbg_cnt !== '0 || dbg_last !== 1'b1) begin
      fails++;
      $display("FAIL reset_values: got post=%h state=%0d cnt=%0d last=%b want 0/IDLE/0/1",
               o_post, dbg_state, dbg_cnt, dbg_last);
    end
  endtask

  task automatic test_tie_burst();
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
      tests++;
      if ({o_pre, o_post} !== {e_pre, e_post}) begin
        fails++;
        $display("FAIL tie cyc%0d: got %h want %h", i, {o_pre, o_post}, {e_pre, e_post});
      end
      if (sb_got) begin
        tests++;
        if (sb_obs !== sb_exp) begin
          fails++;
          $display("FAIL tie_sb cyc%0d: got %h want %h", i, sb_obs, sb_exp);
        end
      end
      if (i == 0 || i == 4) begin
        tests++;
        if (o_post !== ((i == 0) ? {2'b10, 8'h11} : {2'b11, 8'h22})) begin
          fails++;
          $display("FAIL tie_order beat%0d: got %h", i + 1, o_post);
        end
      end
    end
  endtask

  task automatic test_single_requester();
    bit a_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b0, 1'b0, 8'h00, 1'b1, 8'($urandom_range(0, 255)), 1'b1);
      a_seen |= o_pre[2];
      tests++;
      if ({o_pre, o_post} !== {e_pre, e_post}) begin
        fails++;
        $display("FAIL single cyc%0d: got %h want %h", i, {o_pre, o_post}, {e_pre, e_post});
      end
      if (sb_got) begin
        tests++;
        if (sb_obs !== sb_exp) begin
          fails++;
          $display("FAIL single_sb cyc%0d: got %h want %h", i, sb_obs, sb_exp);
        end
      end
    end
    tests++;
    if (dbg_cnt !== CW'(MAXB) || a_seen) begin
      fails++;
      $display("FAIL single_sat: got cnt=%0d a_ready_seen=%b want cnt=%0d a_ready_seen=0",
               dbg_cnt, a_seen, MAXB);
    end
  endtask

  task automatic test_backpressure();
    logic [K+1:0] held;
    drive_cycle(1'b0, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b1);
    held = o_post;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b1, 8'($urandom_range(0, 255)), 1'b0);
      tests++;
      if (o_pre !== 3'b000 && o_pre !== 3'b001 || o_post !== {2'b10, 8'h3C}) begin
        fails++;
        $display("FAIL bp_hold cyc%0d: got pre=%b post=%h want ready=0 post=%h", i, o_pre, o_post, held);
      end
      tests++;
      if ({o_pre, o_post} !== {e_pre, e_post}) begin
        fails++;
        $display("FAIL bp cyc%0d: got %h want %h", i, {o_pre, o_post}, {e_pre, e_post});
      end
    end
    drive_cycle(1'b0, 1'b1, 8'h77, 1'b1, 8'h88, 1'b1);
    tests++;
    if ((o_pre[2] | o_pre[1]) !== 1'b1 || {o_pre, o_post} !== {e_pre, e_post}) begin
      fails++;
      $display("FAIL bp_release: got %h want %h", {o_pre, o_post}, {e_pre, e_post});
    end
    tests++;
    if (!sb_got || sb_obs !== sb_exp) begin
      fails++;
      $display("FAIL bp_sb: got %h (taken=%b) want %h", sb_obs, sb_got, sb_exp);
    end
  endtask

  task automatic test_idle_gap();
    drive_cycle(1'b0, 1'b1, 8'h41, 1'b0, 8'h00, 1'b1);
    drive_cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    tests++;
    if (o_post[K+1] !== 1'b0 || dbg_state !== IDLE || o_post !== e_post) begin
      fails++;
      $display("FAIL idle_gap: got post=%h state=%0d want post=%h state=IDLE", o_post, dbg_state, e_post);
    end
    drive_cycle(1'b0, 1'b1, 8'h51, 1'b1, 8'h62, 1'b1);
    tests++;
    if (o_post !== {2'b11, 8'h62} || o_pre !== e_pre) begin
      fails++;
      $display("FAIL idle_tie: got pre=%b post=%h want pre=%b post=%h", o_pre, o_post, e_pre, {2'b11, 8'h62});
    end
  endtask

  task automatic test_mid_reset();
    drive_cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    drive_cycle(1'b0, 1'b1, 8'h01, 1'b0, 8'h00, 1'b1);
    drive_cycle(1'b0, 1'b1, 8'h02, 1'b0, 8'h00, 1'b1);
    drive_cycle(1'b1, 1'b1, 8'h03, 1'b0, 8'h00, 1'b1);
    tests++;
    if (o_pre !== 3'b000 || o_post !== '0 || dbg_state !== IDLE || dbg_cnt !== '0) begin
      fails++;
      $display("FAIL mid_reset: got pre=%b post=%h state=%0d cnt=%0d want 000/0/IDLE/0",
               o_pre, o_post, dbg_state, dbg_cnt);
    end
    drive_cycle(1'b0, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1);
    tests++;
    if (o_post !== {2'b10, 8'hAA}) begin
      fails++;
      $display("FAIL post_reset_tie: got %h want %h", o_post, {2'b10, 8'hAA});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive_cycle($urandom_range(0, 49) == 0,
                  $urandom_range(0, 2) != 0, 8'($urandom_range(0, 255)),
                  $urandom_range(0, 2) != 0, 8'($urandom_range(0, 255)),
                  $urandom_range(0, 3) != 0);
      tests++;
      if ({o_pre, o_post} !== {e_pre, e_post}) begin
        fails++;
        $display("FAIL random cyc%0d: got %h want %h", i, {o_pre, o_post}, {e_pre, e_post});
      end
      if (sb_got) begin
        tests++;
        if (sb_obs !== sb_exp) begin
          fails++;
          $display("FAIL random_sb cyc%0d: got %h want %h", i, sb_obs, sb_exp);
        end
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst         = 1'b1;
    bus.A_VALID = 1'b0;
    bus.A_DATA  = '0;
    bus.B_VALID = 1'b0;
    bus.B_DATA  = '0;
    bus.O_READY = 1'b0;
    model_reset();
    test_reset();
    test_tie_burst();
    test_single_requester();
    test_backpressure();
    test_idle_gap();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
